// File: rtl/image_ram_pkg.sv
// Shared definitions for the image RAM with stream dump engine.
// Optional build macro used by image_ram_stream: IMAGE_RAM_RDW_BYPASS_EN.
package image_ram_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 12;

    // Dump engine sequencing.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DUMP  = 2'd1,
        ST_DRAIN = 2'd2
    } dump_state_t;

    // Base plus offset, wrapped to a power-of-two address space of 'width' bits.
    function automatic logic [31:0] wrap_addr(
        input logic [31:0] base,
        input logic [31:0] offset,
        input int unsigned width
    );
        logic [31:0] mask;
        if (width >= 32'd32) begin
            mask = 32'hFFFF_FFFF;
        end else begin
            mask = (32'd1 << width) - 32'd1;
        end
        return (base + offset) & mask;
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready skid buffer. The producer never sees backpressure
// directly; instead it reads free_cnt and only pushes when a slot is free.
// The head entry drives the outputs from a register, so the payload holds
// steady while the sink stalls.
module stream_skid_buf #(
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       free_cnt
);

    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] tail_r;
    logic [1:0]       count_r;
    logic             pop_s;

    // Handshake decode for the head entry.
    always_comb begin
        pop_s = (count_r != 2'd0) & out_ready;
    end

    // Push into the first empty slot, pop by shifting the tail into the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
        end else begin
            case ({in_valid, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_r  <= in_data;
                        count_r <= 2'd1;
                    end else if (count_r == 2'd1) begin
                        tail_r  <= in_data;
                        count_r <= 2'd2;
                    end else begin
                        count_r <= count_r;
                    end
                end
                2'b01: begin
                    head_r  <= tail_r;
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        head_r <= in_data;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= in_data;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign out_valid = (count_r != 2'd0);
    assign out_data  = head_r;
    assign free_cnt  = 2'd2 - count_r;

endmodule

// File: rtl/image_ram_stream.sv
// Single-clock image RAM with a processor port and a window dump engine that
// streams words out over valid/ready.
// Build macro IMAGE_RAM_RDW_BYPASS_EN: when defined, a same-cycle processor
// write and read returns the new data (write-first); otherwise read-first.
module image_ram_stream
    import image_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    input  logic                  dump_start,
    input  logic [ADDR_WIDTH-1:0] dump_base,
    input  logic [LEN_WIDTH-1:0]  dump_len,
    output logic                  busy,
    output logic                  dump_done,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_last
);

    localparam int DEPTH         = 2 ** ADDR_WIDTH;
    localparam int PAYLOAD_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam logic [LEN_WIDTH-1:0] DEPTH_LEN = LEN_WIDTH'(DEPTH);
    localparam logic [LEN_WIDTH-1:0] ONE_LEN   = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] ZERO_LEN  = LEN_WIDTH'(0);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    dump_state_t              state_r;
    logic                     busy_r;
    logic                     dump_done_r;
    logic [ADDR_WIDTH-1:0]    base_r;
    logic [LEN_WIDTH-1:0]     len_r;
    logic [LEN_WIDTH-1:0]     issue_cnt_r;

    // In-flight read stage between the RAM and the skid buffer.
    logic                     rd_pend_r;
    logic [DATA_WIDTH-1:0]    rd_data_r;
    logic [ADDR_WIDTH-1:0]    rd_addr_r;
    logic                     rd_last_r;

    logic [DATA_WIDTH-1:0]    data_out_r;
    logic                     rd_valid_r;

    logic                     proc_wr_s;
    logic                     proc_rd_s;
    logic [DATA_WIDTH-1:0]    proc_word_s;
    logic [LEN_WIDTH-1:0]     start_len_s;
    logic [ADDR_WIDTH-1:0]    rd_ptr_s;
    logic [1:0]               free_cnt_s;
    logic                     out_valid_s;
    logic                     pop_s;
    logic                     issue_s;
    logic                     issue_last_s;
    logic [PAYLOAD_WIDTH-1:0] in_payload_s;
    logic [PAYLOAD_WIDTH-1:0] out_payload_s;

    // Access gating, length clamp, issue decision and next read address.
    always_comb begin
        proc_wr_s = ~busy_r & w_en;
        proc_rd_s = ~busy_r & r_en;

`ifdef IMAGE_RAM_RDW_BYPASS_EN
        if (proc_wr_s) begin
            proc_word_s = data_in;
        end else begin
            proc_word_s = mem[address];
        end
`else
        proc_word_s = mem[address];
`endif

        if (dump_len > DEPTH_LEN) begin
            start_len_s = DEPTH_LEN;
        end else begin
            start_len_s = dump_len;
        end

        rd_ptr_s = ADDR_WIDTH'(wrap_addr(32'(base_r), 32'(issue_cnt_r), ADDR_WIDTH));
        pop_s    = out_valid_s & m_ready;

        // A slot is available if the buffer has room after this cycle's pop
        // once the read already in flight has been accounted for.
        if ((state_r == ST_DUMP) && (issue_cnt_r != len_r)) begin
            issue_s = ({1'b0, free_cnt_s} + {2'b00, pop_s}) > {2'b00, rd_pend_r};
        end else begin
            issue_s = 1'b0;
        end

        issue_last_s = ((issue_cnt_r + ONE_LEN) == len_r);
        in_payload_s = {rd_data_r, rd_addr_r, rd_last_r};
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (proc_wr_s) begin
            mem[address] <= data_in;
        end
    end

    // Processor read port: registered data with a one-cycle valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_r <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= proc_rd_s;
            if (proc_rd_s) begin
                data_out_r <= proc_word_s;
            end
        end
    end

    // Dump FSM with its read-issue stage, busy and done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            dump_done_r <= 1'b0;
            base_r      <= '0;
            len_r       <= '0;
            issue_cnt_r <= '0;
            rd_pend_r   <= 1'b0;
            rd_data_r   <= '0;
            rd_addr_r   <= '0;
            rd_last_r   <= 1'b0;
        end else begin
            dump_done_r <= 1'b0;
            rd_pend_r   <= issue_s;
            if (issue_s) begin
                rd_data_r   <= mem[rd_ptr_s];
                rd_addr_r   <= rd_ptr_s;
                rd_last_r   <= issue_last_s;
                issue_cnt_r <= issue_cnt_r + ONE_LEN;
            end
            case (state_r)
                ST_IDLE: begin
                    if (dump_start) begin
                        base_r      <= dump_base;
                        len_r       <= start_len_s;
                        issue_cnt_r <= ZERO_LEN;
                        if (start_len_s == ZERO_LEN) begin
                            dump_done_r <= 1'b1;
                        end else begin
                            state_r <= ST_DUMP;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                ST_DUMP: begin
                    if (issue_s && issue_last_s) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop_s && out_payload_s[0]) begin
                        state_r     <= ST_IDLE;
                        busy_r      <= 1'b0;
                        dump_done_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    stream_skid_buf #(
        .WIDTH(PAYLOAD_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (rd_pend_r),
        .in_data  (in_payload_s),
        .out_valid(out_valid_s),
        .out_ready(m_ready),
        .out_data (out_payload_s),
        .free_cnt (free_cnt_s)
    );

    assign data_out  = data_out_r;
    assign rd_valid  = rd_valid_r;
    assign busy      = busy_r;
    assign dump_done = dump_done_r;
    assign m_valid   = out_valid_s;
    assign m_data    = out_payload_s[PAYLOAD_WIDTH-1 -: DATA_WIDTH];
    assign m_addr    = out_payload_s[ADDR_WIDTH:1];
    assign m_last    = out_payload_s[0];

endmodule

// File: doc/image_ram_stream.md
Name: image_ram_stream

Overview:
- Parametrised single-clock image RAM for the convolution processor.
- Processor port: 1-cycle-latency read/write with a read-valid flag.
- Dump engine: on a `dump_start` pulse, streams a programmable address window out on a valid/ready stream (`m_*`), one word per beat, with a last flag and a done pulse.
- Supersedes simulation-only file dumping; the testbench or a downstream writer consumes the stream.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 12, address width; depth = 2**ADDR_WIDTH words.
- LEN_WIDTH, ADDR_WIDTH+1, width of dump length; allows a full-depth dump.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- w_en  in  1  processor write enable.
- r_en  in  1  processor read enable.
- address  in  ADDR_WIDTH  processor address.
- data_in  in  DATA_WIDTH  processor write data.
- data_out  out  DATA_WIDTH  processor read data, registered.
- rd_valid  out  1  high the cycle after an accepted read.
- dump_start  in  1  one-cycle pulse that requests a dump.
- dump_base  in  ADDR_WIDTH  first dump address, sampled with dump_start.
- dump_len  in  LEN_WIDTH  word count, sampled with dump_start.
- busy  out  1  dump in progress.
- dump_done  out  1  one-cycle pulse when the dump completes.
- m_valid  out  1  stream data valid.
- m_ready  in  1  stream sink ready.
- m_data  out  DATA_WIDTH  stream word.
- m_addr  out  ADDR_WIDTH  RAM address of m_data.
- m_last  out  1  final beat of the dump.

Behaviour:
- Reset (async assert, sync release):
  - data_out, rd_valid, busy, dump_done, m_valid, m_data, m_addr, m_last all 0.
  - FSM returns to IDLE.
  - RAM contents are not cleared.
  - Reset mid-dump aborts the dump immediately; no dump_done is issued.
- Processor port:
  - Write: w_en=1 writes data_in to ram[address] at the edge.
  - Read: r_en=1 registers ram[address] into data_out at the edge; rd_valid=1 for that following cycle.
  - data_out holds its value when r_en=0.
  - Same-cycle read and write to the same address is read-first: data_out returns the old word (see optional feature).
  - Processor accesses are ignored while busy=1; rd_valid stays 0.
- FSM states:
  - IDLE: dump_start=1 latches base/len. If len=0, pulse dump_done the next cycle and stay in IDLE. Otherwise go to DUMP with busy=1 from the next cycle. A processor access in the dump_start cycle is still performed.
  - DUMP: issue at most one RAM read per cycle, at rd_ptr = base + issued_count (mod 2**ADDR_WIDTH, wrapping past the top). Issue only when the skid buffer has a free slot counting in-flight reads. Go to DRAIN after len reads have been issued.
  - DRAIN: wait until the final beat handshakes (m_valid & m_ready & m_last), then go to IDLE. busy=0 and dump_done=1 in the cycle after that handshake.
  - dump_start while busy is ignored.
- Stream rules:
  - Beats are in address order.
  - m_data, m_addr and m_last hold stable while m_valid=1 and m_ready=0.
  - m_last=1 only on beat number len.
  - Minimum latency: dump_start sampled at edge N → first read issued at N+1 → m_valid=1 after edge N+2.
  - Throughput is 1 beat/cycle with m_ready held high.
  - No beat is lost or duplicated under any m_ready pattern.
- Widths:
  - Beat counter and issue counter are LEN_WIDTH bits.
  - Address arithmetic is ADDR_WIDTH bits and truncates (wrap-around).
  - A dump_len greater than 2**ADDR_WIDTH is clamped to 2**ADDR_WIDTH.

Optional Feature:
- Macro: IMAGE_RAM_RDW_BYPASS_EN.
- Defined: a same-cycle write and read to the same address returns data_in on data_out (write-first forwarding).
- Undefined: read-first, returning the old word.
- The dump path is unaffected either way.

Decomposition:
- Shared package image_ram_pkg holds:
  - FSM state typedef (IDLE, DUMP, DRAIN).
  - Default DATA_WIDTH / ADDR_WIDTH constants.
  - A helper function computing wrapped addresses.
- Sub-module stream_skid_buf: 2-entry valid/ready skid buffer, parametrised on payload width (DATA_WIDTH + ADDR_WIDTH + 1), exposing a free-slot count to the issue logic.

Test Plan:
- Processor access: write 0xA5 @0x010, then r_en @0x010 → data_out=0xA5 with rd_valid=1 exactly one cycle later. Same-cycle write 0x3C / read @0x010 → 0xA5 without the macro, 0x3C with it.
- Basic dump: fill ram[i]=i[7:0], dump_base=0x000, dump_len=4, m_ready=1 → beats 0,1,2,2,3 are not allowed; required beats 0x00,0x01,0x02,0x03 on consecutive cycles with m_valid first high 2 cycles after dump_start, m_last on 0x03, dump_done the cycle after.
- Wrap-around: dump_base=0xFFE, dump_len=4 → m_addr sequence 0xFFE, 0xFFF, 0x000, 0x001 with matching data.
- Backpressure: full-depth dump (len=4096) with m_ready toggling on a pseudo-random pattern → exactly 4096 beats in order, payload stable while stalled, single m_last and single dump_done.
- Edge cases:
  - dump_len=0 → dump_done pulse, busy never asserts, no m_valid.
  - dump_start while busy → ignored.
  - w_en while busy → RAM unchanged.
- Reset mid-dump: assert rst_n=0 after 10 beats → all outputs 0 asynchronously, no dump_done. A new dump after release starts cleanly from its own dump_base.
